act_stream: RTL and testbench

- Streaming, multi-channel activation unit for the CNN datapath; the parametrised successor of the combinational ReLU stage.
- Sits between the convolution/adder outputs and pooling.
- Applies a selectable activation per frame (bypass, ReLU, leaky ReLU, clipped ReLU) to CH lanes in parallel, saturates each lane to the output width, and uses a valid/ready handshake with a 2-stage pipeline.
- Reports the per-frame count of zero outputs for sparsity monitoring.

---
 rtl/act_stream.sv | 216 +++++++++++++++++++++
 tb/tb_act_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_stream.sv
//------------------------------------------------------------------------------
// act_stream
//   Streaming multi-lane activation unit placed between the convolution/adder
//   outputs and pooling. Each frame uses a single activation function:
//   bypass, ReLU, leaky ReLU or clipped ReLU. The function is applied to CH
//   lanes in parallel, and each lane is then saturated to W_OUT bits.
//
//   The pipeline has two register stages with a valid/ready handshake:
//     S1 : activation result register
//     S2 : saturated output register (drives out_*)
//   Both stages advance together whenever the output is free or is being
//   taken. The unit also counts zero output lanes per frame, which is used
//   for sparsity monitoring.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   mode           0=bypass 1=ReLU 2=leaky 3=clip; sampled on first beat
//   clip_val       unsigned clip ceiling; sampled together with mode
//   in_valid       input beat valid
//   in_ready       input beat accepted when in_valid & in_ready
//   in_data        CH signed lanes; lane c at [c*W_IN +: W_IN]
//   in_last        last beat of frame
//   out_valid      output beat valid
//   out_ready      downstream ready
//   out_data       CH signed lanes; lane c at [c*W_OUT +: W_OUT]
//   out_last       in_last travelling with its beat
//   frame_zero_cnt zero-lane count of the last completed frame
//   frame_done     one-cycle pulse when frame_zero_cnt updates
//------------------------------------------------------------------------------
module act_stream #(
   parameter int W_IN       = 9,
   parameter int W_OUT      = 8,
   parameter int CH         = 4,
   parameter int LEAK_SHIFT = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            mode,
   input  logic [W_IN-2:0]       clip_val,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH*W_IN-1:0]    in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH*W_OUT-1:0]   out_data,
   output logic                  out_last,
   output logic [CNT_W-1:0]      frame_zero_cnt,
   output logic                  frame_done
);

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_RELU   = 2'd1,
      MODE_LEAKY  = 2'd2,
      MODE_CLIP   = 2'd3
   } mode_e;

   // A common width that holds both the input and the output range. This
   // lets saturation compare values without losing the sign.
   localparam int W_MX = (W_IN > W_OUT) ? W_IN : W_OUT;
   localparam logic signed [W_MX-1:0] SAT_MAX = {{(W_MX-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
   localparam logic signed [W_MX-1:0] SAT_MIN = ~SAT_MAX;
   localparam int ZW = $clog2(CH+1);

   // The activation result always fits in W_IN bits. The clip ceiling is
   // non-negative and narrower than W_IN.
   function automatic logic signed [W_IN-1:0] f_act(
      input logic signed [W_IN-1:0] x,
      input mode_e                  m,
      input logic [W_IN-2:0]        cv
   );
      logic signed [W_IN-1:0] ceil_v;
      logic signed [W_IN-1:0] y;
      ceil_v = $signed({1'b0, cv});
      y      = x;
      case (m)
         MODE_BYPASS: y = x;
         MODE_RELU:   y = (x > 0) ? x : '0;
         MODE_LEAKY:  y = (x > 0) ? x : (x >>> LEAK_SHIFT);
         MODE_CLIP: begin
            if (x <= 0)          y = '0;
            else if (x > ceil_v) y = ceil_v;
            else                 y = x;
         end
         default:     y = x;
      endcase
      return y;
   endfunction

   function automatic logic [W_OUT-1:0] f_sat(input logic signed [W_IN-1:0] x);
      logic signed [W_MX-1:0] e;
      e = W_MX'(x);
      if (e > SAT_MAX)      e = SAT_MAX;
      else if (e < SAT_MIN) e = SAT_MIN;
      return e[W_OUT-1:0];
   endfunction

   // State
   logic                  r_s1_valid;
   logic                  r_s1_last;
   logic [CH*W_IN-1:0]    r_s1_data;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic [CH*W_OUT-1:0]   r_out_data;
   logic                  r_first;
   mode_e                 r_mode;
   logic [W_IN-2:0]       r_clip;
   logic [CNT_W-1:0]      r_run;
   logic [CNT_W-1:0]      r_frame_cnt;
   logic                  r_done;

   // Combinational
   logic                  w_en;
   logic                  w_accept;
   logic                  w_out_hs;
   mode_e                 w_mode;
   logic [W_IN-2:0]       w_clip;
   logic [CH*W_IN-1:0]    w_act;
   logic [CH*W_OUT-1:0]   w_sat;
   logic [ZW-1:0]         w_zeros;
   logic [CNT_W:0]        w_sum;
   logic [CNT_W-1:0]      w_sum_sat;

   // The pipeline moves as one unit. A bubble in S2 is squeezed out even
   // while downstream is not ready.
   assign w_en     = !r_out_valid || out_ready;
   assign w_accept = in_valid && w_en;
   assign w_out_hs = r_out_valid && out_ready;

   // The first beat of a frame uses the live mode/clip inputs. Later beats
   // use the copies latched on that first beat.
   assign w_mode = r_first ? mode_e'(mode) : r_mode;
   assign w_clip = r_first ? clip_val : r_clip;

   always_comb begin
      // NOTE: give every always_comb output a default first, so that no path
      // leaves a value held and a latch is inferred.
      w_act = '0;
      w_sat = '0;
      for (int c = 0; c < CH; c++) begin
         w_act[c*W_IN +: W_IN]   = f_act(in_data[c*W_IN +: W_IN], w_mode, w_clip);
         w_sat[c*W_OUT +: W_OUT] = f_sat(r_s1_data[c*W_IN +: W_IN]);
      end
   end

   always_comb begin
      w_zeros = '0;
      for (int c = 0; c < CH; c++) begin
         if (r_out_data[c*W_OUT +: W_OUT] == '0) w_zeros = w_zeros + ZW'(1);
      end
   end

   // The running count sticks at all-ones instead of wrapping.
   assign w_sum     = {1'b0, r_run} + (CNT_W+1)'(w_zeros);
   assign w_sum_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only. This
         // way every register samples its pre-edge inputs.
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_first     <= 1'b1;
         r_mode      <= MODE_RELU;
         r_clip      <= '0;
         r_run       <= '0;
         r_frame_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_last   <= in_last;
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            // Data only moves with a valid beat. An idle cycle keeps the
            // old value, so the data lines do not toggle.
            if (in_valid)   r_s1_data  <= w_act;
            if (r_s1_valid) r_out_data <= w_sat;
         end

         if (w_accept) begin
            if (r_first) begin
               r_mode <= w_mode;
               r_clip <= clip_val;
            end
            r_first <= in_last;
         end

         r_done <= 1'b0;
         if (w_out_hs) begin
            if (r_out_last) begin
               r_frame_cnt <= w_sum_sat;
               r_run       <= '0;
               r_done      <= 1'b1;
            end else begin
               r_run       <= w_sum_sat;
            end
         end
      end
   end

   assign in_ready       = w_en;
   assign out_valid      = r_out_valid;
   assign out_data       = r_out_data;
   assign out_last       = r_out_last;
   assign frame_zero_cnt = r_frame_cnt;
   assign frame_done     = r_done;

endmodule

// File: tb/tb_act_stream.sv
//------------------------------------------------------------------------------
// tb_act_stream
//   Scoreboard bench for act_stream. The driver passes each accepted beat
//   through a reference model. The model applies the activation rules and
//   saturation to each lane as plain integers, and queues the expected
//   output beat and the expected per-frame zero count. A separate monitor
//   pops these queues whenever the DUT hands over a beat or pulses
//   frame_done.
//------------------------------------------------------------------------------
module tb_act_stream;

   localparam int W_IN  = 9;
   localparam int W_OUT = 8;
   localparam int CH    = 4;
   localparam int LS    = 3;
   localparam int CNT_W = 16;

   typedef int lanes_t [CH];
   typedef struct {
      logic [CH*W_OUT-1:0] data;
      logic                last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            mode;
   logic [W_IN-2:0]       clip_val;
   logic                  in_valid;
   logic                  in_ready;
   logic [CH*W_IN-1:0]    in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [CH*W_OUT-1:0]   out_data;
   logic                  out_last;
   logic [CNT_W-1:0]      frame_zero_cnt;
   logic                  frame_done;

   act_stream #(.W_IN(W_IN), .W_OUT(W_OUT), .CH(CH), .LEAK_SHIFT(LS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .clip_val(clip_val),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .frame_zero_cnt(frame_zero_cnt), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    cnt_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    ready_mode  = 0;   // 0: always ready, 1: random, 2: held low

   // Reference model state
   int m_first, m_mode, m_clip, m_run;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_first = 1; m_mode = 1; m_clip = 0; m_run = 0;
      exp_q.delete();
      cnt_q.delete();
   endtask

   function automatic int ref_lane(input int x, input int m, input int cv);
      int y;
      int hi, lo;
      case (m)
         0:       y = x;
         1:       y = (x > 0) ? x : 0;
         2:       y = (x > 0) ? x : -((-x + (1 << LS) - 1) / (1 << LS));  // floor(x / 2^LS)
         default: y = (x <= 0) ? 0 : ((x < cv) ? x : cv);
      endcase
      hi = (1 << (W_OUT-1)) - 1;
      lo = -(1 << (W_OUT-1));
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      return y;
   endfunction

   task automatic model_accept(input lanes_t lanes, input bit last, input int m, input int cv);
      beat_t b;
      int    y;
      int    zeros;
      if (m_first != 0) begin
         m_mode = m;
         m_clip = cv;
      end
      b.data = '0;
      b.last = last;
      zeros  = 0;
      for (int c = 0; c < CH; c++) begin
         y = ref_lane(lanes[c], m_mode, m_clip);
         if (y == 0) zeros++;
         b.data[c*W_OUT +: W_OUT] = y[W_OUT-1:0];
      end
      exp_q.push_back(b);
      m_run = m_run + zeros;
      if (m_run > (1 << CNT_W) - 1) m_run = (1 << CNT_W) - 1;
      if (last) begin
         cnt_q.push_back(m_run);
         m_run = 0;
      end
      m_first = last ? 1 : 0;
   endtask

   // Called at posedge+1. Returns at posedge+1 right after the beat was taken.
   task automatic send_beat(input lanes_t lanes, input bit last, input int m, input int cv);
      bit taken = 0;
      in_valid = 1'b1;
      in_last  = last;
      mode     = m[1:0];
      clip_val = cv[W_IN-2:0];
      for (int c = 0; c < CH; c++) in_data[c*W_IN +: W_IN] = lanes[c][W_IN-1:0];
      for (int t = 0; t < 200 && !taken; t++) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(lanes, last, m, cv);
            @(posedge clk);
            #1;
            taken = 1;
         end
      end
      if (!taken) check("accept_timeout", {63'd0, taken}, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit empty = 0;
      for (int t = 0; t < 300 && !empty; t++) begin
         @(negedge clk);
         empty = (exp_q.size() == 0) && (cnt_q.size() == 0);
      end
      if (!empty) check("drain_timeout", 64'(exp_q.size() + cnt_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int exp);
      bit seen = 0;
      for (int t = 0; t < 30 && !seen; t++) begin
         @(negedge clk);
         if (frame_done) begin
            seen = 1;
            check(name, 64'(frame_zero_cnt), 64'(exp));
            @(negedge clk);
            check({name, "_pulse"}, {63'd0, frame_done}, 64'd0);
         end
      end
      if (!seen) check({name, "_timeout"}, {63'd0, seen}, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Downstream ready generator
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) < 70);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      beat_t e;
      int    ec;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid && !out_ready) check("in_ready_stall", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", {63'd0, out_valid}, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", 64'(out_data), 64'(e.data));
                  check("out_last", {63'd0, out_last}, {63'd0, e.last});
               end
            end
            if (frame_done) begin
               if (cnt_q.size() == 0) begin
                  check("unexpected_frame_done", {63'd0, frame_done}, 64'd0);
               end else begin
                  ec = cnt_q.pop_front();
                  check("frame_zero_cnt", 64'(frame_zero_cnt), 64'(ec));
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      lanes_t l;
      int     frame_len;
      int     fm;
      int     edge_vals [9];
      edge_vals = '{0, -1, 1, 127, 128, -128, -129, 255, -256};
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      mode     = 2'd0;
      clip_val = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", {63'd0, out_last}, 64'd0);
      check("rst_zero_cnt", 64'(frame_zero_cnt), 64'd0);
      check("rst_frame_done", {63'd0, frame_done}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ReLU with latency check: nothing one edge after acceptance, beat after the next
      send_beat('{-5, 0, 100, 255}, 1, 1, 0);
      @(negedge clk);
      check("lat_stage1_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      check("lat_out_valid", {63'd0, out_valid}, 64'd1);
      check("relu_data", 64'(out_data), 64'h7f64_0000);
      @(posedge clk);
      #1;
      drain();

      // Leaky and bypass
      send_beat('{-8, -256, 16, -1}, 1, 2, 0);
      send_beat('{-200, 200, -128, 127}, 1, 0, 0);
      drain();

      // Clip; mid-frame mode/clip change is ignored, the next frame uses bypass
      send_beat('{70, -3, 60, 59}, 0, 3, 60);
      send_beat('{100, 61, -1, 5}, 1, 0, 10);
      send_beat('{100, 61, -1, 5}, 1, 0, 10);
      drain();

      // Backpressure: 6 back-to-back beats, downstream stalls 5 cycles mid-stream
      fork
         begin
            for (int b = 0; b < 6; b++) begin
               for (int c = 0; c < CH; c++) l[c] = int'($urandom_range(0, 511)) - 256;
               send_beat(l, (b == 5), 1, 0);
            end
         end
         begin
            repeat (3) @(posedge clk);
            ready_mode = 2;
            repeat (5) @(posedge clk);
            ready_mode = 0;
         end
      join
      drain();

      // Zero count: 5 zero lanes over a 3-beat ReLU frame, then a frame with none
      send_beat('{-1, 0, 5, 6}, 0, 1, 0);
      send_beat('{1, -2, 3, 4}, 0, 1, 0);
      send_beat('{0, 7, -9, 8}, 1, 1, 0);
      wait_done("zc_three_beat", 5);
      send_beat('{1, 2, 3, 4}, 1, 1, 0);
      wait_done("zc_no_zeros", 0);
      drain();

      // Reset with two beats of an unfinished frame in flight
      send_beat('{3, -3, 0, 9}, 0, 2, 0);
      send_beat('{4, -4, 0, 8}, 0, 2, 0);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_zero_cnt", 64'(frame_zero_cnt), 64'd0);
      @(posedge clk);
      #1;
      // This beat is the first of a new frame, so its bypass mode applies
      send_beat('{-5, 0, 3, -100}, 1, 0, 0);
      wait_done("midrst_new_frame", 1);
      drain();

      // Randomised traffic with random downstream backpressure
      ready_mode = 1;
      for (int f = 0; f < 80; f++) begin
         frame_len = $urandom_range(1, 6);
         for (int b = 0; b < frame_len; b++) begin
            for (int c = 0; c < CH; c++) begin
               if ($urandom_range(0, 3) == 0) l[c] = edge_vals[$urandom_range(0, 8)];
               else                           l[c] = int'($urandom_range(0, 511)) - 256;
            end
            fm = $urandom_range(0, 3);
            send_beat(l, (b == frame_len - 1), fm, $urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
      end
      ready_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
